instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- PC-generation and fetch stage between the core's redirect sources (branch/jump/trap) and the instruction memory port.
- Drives the memory address, waits for the memory acknowledge, and pushes {PC, instruction} into a 2-entry fetch queue.
- Decode drains the queue with a valid/ready handshake.
- On redirect, discards all in-flight and queued instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value fetched first after reset.
- QDEPTH, 2, fetch-queue entries; power of two, minimum 2.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- o_IAddr  out  `XLEN  byte address presented to instruction memory.
- o_IReq  out  1  memory request valid.
- i_IAck  in  1  memory response valid; i_IData is valid in the same cycle.
- i_IData  in  `INSTRUCTION_SIZE+1  instruction word returned by memory.
- i_Redirect  in  1  one-cycle redirect pulse from execute/trap logic.
- i_RedirectPC  in  `XLEN  redirect target address.
- o_Valid  out  1  queue head is valid.
- i_Ready  in  1  decode accepts the head this cycle.
- o_Instr  out  `INSTRUCTION_SIZE+1  instruction at queue head.
- o_PC  out  `XLEN  PC of the instruction at queue head.

Behaviour:
- Reset values (async, i_rstn=0): pc=RESET_VECTOR, state=IDLE, queue empty, o_IReq=0, o_Valid=0, o_IAddr=RESET_VECTOR, o_Instr=0, o_PC=0.
- FSM states:
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ: o_IReq=1 while the queue has a free slot, counting the outstanding slot.
    - o_IAddr=pc, held stable until ack.
    - i_IAck → push {pc, i_IData}, pc+=4, stay in REQ (back-to-back fetch, throughput 1 instr/cycle with a zero-wait memory).
    - Queue full → o_IReq=0, stay in REQ.
  - DROP: entered on a redirect while a request is unacknowledged.
    - o_IReq is held high at the old address until i_IAck.
    - The ack's data is discarded, then return to REQ at the redirect target.
- i_Redirect has priority over everything in that cycle:
  - Queue flushed (o_Valid=0 next cycle), even if i_Ready=1 that cycle; the pop is ignored.
  - pc=i_RedirectPC.
  - If an ack coincides with the redirect, its data is dropped and no DROP state is needed.
- Memory latency:
  - Zero-wait memory (i_IAck same cycle as o_IReq) gives o_Valid one cycle after the request.
  - Arbitrary wait states are legal.
- Queue:
  - Circular buffer with wrapping read/write pointers and count; pop when o_Valid&&i_Ready.
  - Simultaneous push and pop on a full queue is permitted (count unchanged).
  - o_Instr/o_PC are the registered head entry; they are undefined when o_Valid=0, and the bench must not check them then.
- pc arithmetic is modulo 2^`XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request: o_IReq drops immediately (async), and any outstanding ack after release is not expected.

Optional Feature:
- FETCH_MISALIGN_EXC_EN defined:
  - Adds output o_Misaligned (1 bit, reset 0).
  - A redirect whose target has i_RedirectPC[1:0]!=0 does not fetch. It pushes a single entry with o_Instr=32'h0000_0013 (NOP), o_PC=target, o_Misaligned=1.
  - Fetch then stalls until the next redirect.
- Undefined: bits [1:0] of the redirect target are forced to 0 and there is no extra port.

Decomposition:
- Shared defines header: `XLEN, `INSTRUCTION_SIZE, NOP encoding, FSM state encodings (IDLE/REQ/DROP).
- Sub-module fetch_queue (parameterised FIFO, push/pop/flush, full/empty) instantiated once.

Test Plan:
1. Reset release, zero-wait memory returning addr-based words, i_Ready=1 → o_IAddr sequence 0,4,8,…; o_Valid first high 2 cycles after release; o_PC matches each word.
2. i_Ready=0 for 10 cycles → exactly 2 entries queued, o_IReq=0, o_IAddr stable; after i_Ready=1, PCs 0,4,8 delivered in order with none lost.
3. Memory with 3 wait states, i_Redirect to 32'h100 in the wait period → old ack data discarded; next o_Valid shows o_PC=32'h100.
4. Redirect coinciding with i_IAck and i_Ready=1 on a full queue → queue empty next cycle; next fetch at the target.
5. pc=32'hFFFF_FFFC → following fetch address 32'h0000_0000.
6. With FETCH_MISALIGN_EXC_EN, redirect to 32'h102 → one entry with o_Misaligned=1, o_PC=32'h102, o_IReq=0 until a redirect to 32'h200 resumes fetch.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared widths, FSM encodings and fetch-queue payload for the instruction fetch stage.
// Build option FETCH_MISALIGN_EXC_EN adds a misaligned flag to every queue entry.
`ifndef INSTRUCTION_FETCH_DEFS_SVH
`define INSTRUCTION_FETCH_DEFS_SVH
`define XLEN             32
`define INSTRUCTION_SIZE 31
`define NOP_INSTR        32'h0000_0013
`define FETCH_ST_IDLE    2'd0
`define FETCH_ST_REQ     2'd1
`define FETCH_ST_DROP    2'd2
`define FETCH_ST_HALT    2'd3
`endif

package instruction_fetch_pkg;
    localparam int unsigned XLEN = `XLEN;
    localparam int unsigned ILEN = `INSTRUCTION_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE = `FETCH_ST_IDLE,
        ST_REQ  = `FETCH_ST_REQ,
        ST_DROP = `FETCH_ST_DROP,
        ST_HALT = `FETCH_ST_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
`ifdef FETCH_MISALIGN_EXC_EN
        logic            misaligned;
`endif
    } fetch_entry_t;

    // Queue entry reported in place of a fetch from a misaligned target.
    function automatic fetch_entry_t nop_entry(input logic [XLEN-1:0] pc);
        fetch_entry_t e;
        e       = '0;
        e.pc    = pc;
        e.instr = ILEN'(`NOP_INSTR);
`ifdef FETCH_MISALIGN_EXC_EN
        e.misaligned = 1'b1;
`endif
        return e;
    endfunction
endpackage

// File: rtl/instruction_fetch_queue.sv
// Power-of-two circular FIFO with flush; a flush may be combined with a push of the first new entry.
module fetch_queue #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (i_flush) begin
            rptr_d = '0;
            wptr_d = i_push ? PW'(1) : '0;
            cnt_d  = i_push ? CW'(1) : '0;
            if (i_push) mem_d[0] = i_data;
        end else begin
            if (i_push) begin
                mem_d[wptr_q] = i_data;
                wptr_d        = wptr_q + PW'(1);
            end
            if (i_pop) rptr_d = rptr_q + PW'(1);
            cnt_d = cnt_q + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_data  = mem_q[rptr_q];
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;
endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch FSM feeding a small fetch queue drained by decode.
// Build option FETCH_MISALIGN_EXC_EN reports misaligned redirect targets via o_Misaligned.
module instruction_fetch import instruction_fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     QDEPTH       = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    output logic [XLEN-1:0] o_IAddr,
    output logic            o_IReq,
    input  logic            i_IAck,
    input  logic [ILEN-1:0] i_IData,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectPC,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic [ILEN-1:0] o_Instr,
`ifdef FETCH_MISALIGN_EXC_EN
    output logic            o_Misaligned,
`endif
    output logic [XLEN-1:0] o_PC
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic            req_q, req_d;
    logic            push, pop, flush, q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    push_entry, q_head;
    logic [XLEN-1:0] redir_pc;
    logic            redir_mis, tgt_mis;

`ifdef FETCH_MISALIGN_EXC_EN
    assign redir_pc  = i_RedirectPC;
    assign redir_mis = |i_RedirectPC[1:0];
    assign tgt_mis   = |tgt_q[1:0];
`else
    assign redir_pc  = i_RedirectPC & ~XLEN'(3);
    assign redir_mis = 1'b0;
    assign tgt_mis   = 1'b0;
`endif

    // Next-state logic; a redirect overrides every other event in its cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        req_d      = req_q;
        flush      = 1'b0;
        push       = 1'b0;
        pop        = o_Valid && i_Ready;
        push_entry = '0;
        push_entry.pc    = pc_q;
        push_entry.instr = i_IData;
        if (i_Redirect) begin
            flush = 1'b1;
            pop   = 1'b0;
            if (req_q && !i_IAck) begin
                state_d = ST_DROP;
                tgt_d   = redir_pc;
            end else if (redir_mis) begin
                push       = 1'b1;
                push_entry = nop_entry(redir_pc);
                state_d    = ST_HALT;
                pc_d       = redir_pc;
                req_d      = 1'b0;
            end else begin
                state_d = ST_REQ;
                pc_d    = redir_pc;
                req_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
                ST_REQ: begin
                    push = req_q && i_IAck;
                    if (push) pc_d = pc_q + XLEN'(4);
                    // An unacknowledged request already owns a slot and stays up.
                    if (!req_q || i_IAck)
                        req_d = (q_count + CW'(push) - CW'(pop)) < CW'(QDEPTH);
                end
                ST_DROP: begin
                    if (i_IAck) begin
                        pc_d = tgt_q;
                        if (tgt_mis) begin
                            push       = 1'b1;
                            push_entry = nop_entry(tgt_q);
                            state_d    = ST_HALT;
                            req_d      = 1'b0;
                        end else begin
                            state_d = ST_REQ;
                            req_d   = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    req_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= RESET_VECTOR;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
        end
    end

    fetch_queue #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (push),
        .i_data  (push_entry),
        .i_pop   (pop),
        .i_flush (flush),
        .o_data  (q_head),
        .o_empty (q_empty),
        .o_count (q_count)
    );

    assign o_IAddr = pc_q;
    assign o_IReq  = req_q;
    assign o_Valid = !q_empty;
    assign o_Instr = q_head.instr;
    assign o_PC    = q_head.pc;
`ifdef FETCH_MISALIGN_EXC_EN
    assign o_Misaligned = q_head.misaligned;
`endif
endmodule
